simd_rf_wb_arbiter: RTL and testbench
=====================================

SIMD_RF_WB_ARBITER -- requirements
Module: simd_rf_wb_arbiter

Interface
REQ-001 SHALL have parameters:
- width_p, 33: lane data width.
- els_p, 32: register count.
- lanes_p, 4: SIMD lanes per register.
- num_req_p, 3: writeback requesters.
- max_burst_p, 4: maximum beats per locked burst.
- addr_width_lp, 5: log2(els_p).
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports, in order:
- clk_i  in  1  clock
- reset_i  in  1  sync active-high reset
- stall_i  in  1  block all grants this cycle
- req_v_i  in  num_req_p  request valid per requester
- req_burst_i  in  num_req_p  requester wants to hold the grant for further beats
- req_addr_i  in  num_req_p x addr_width_lp  target register
- req_mask_i  in  num_req_p x lanes_p  lane write-enable mask
- req_data_i  in  num_req_p x lanes_p x width_p  lane data
- req_yumi_o  out  num_req_p  one-hot; request consumed this cycle
- w_v_o  out  lanes_p  per-lane write enable to regfile
- w_addr_o  out  addr_width_lp  regfile write address
- w_data_o  out  lanes_p x width_p  regfile write data
- lock_o  out  1  arbiter is in LOCKED state

Function
REQ-003 SHALL implement a two-state FSM: ARB and LOCKED.
REQ-004 SHALL keep the round-robin pointer last_r (last granted index) and the registers owner_r and beat_cnt_r.
REQ-005 In ARB with stall_i=0: SHALL grant the first valid requester scanning from (last_r+1) mod num_req_p upward with wrap, and set last_r to the winner.
REQ-006 SHALL assert req_yumi_o combinationally in the grant cycle t; at most one bit SHALL be set.
REQ-007 Granted beat SHALL appear registered at t+1 for exactly one cycle:
- w_v_o = mask
- w_addr_o = addr
- w_data_o = data
REQ-008 In any cycle without a grant, next-cycle w_v_o SHALL be 0; w_addr_o and w_data_o are don't-care.
REQ-009 A granted request with mask 4'b0000 SHALL still be consumed (yumi=1) and SHALL produce w_v_o=0.
REQ-010 In ARB, if the winner has req_burst_i=1 and max_burst_p>1: SHALL enter LOCKED next cycle with owner_r=winner and beat_cnt_r=1.
REQ-011 In LOCKED, owner valid and stall_i=0: SHALL grant only the owner and increment beat_cnt_r.
REQ-012 In LOCKED, on a granted beat, SHALL return to ARB if:
- owner req_burst_i=0, or
- beat_cnt_r+1 == max_burst_p.
REQ-013 In LOCKED with owner req_v_i=0: SHALL issue no grant and return to ARB next cycle.
REQ-014 In LOCKED, other requesters SHALL never be granted, regardless of their valid.
REQ-015 stall_i=1 SHALL force req_yumi_o=0 and hold FSM, last_r, owner_r and beat_cnt_r unchanged; this overrides REQ-013.
REQ-016 lock_o SHALL be 1 exactly when the state is LOCKED.
REQ-017 Back-to-back grants to the same address SHALL reach the regfile in grant order, one per cycle, no reordering or merging.
REQ-018 SHALL need no backpressure from the regfile; every issued write is assumed taken.

Reset
REQ-019 While reset_i=1 at a clock edge, the block SHALL set:
- state = ARB
- last_r = num_req_p-1 (requester 0 highest priority first)
- owner_r = 0, beat_cnt_r = 0
- w_v_o = 0
REQ-020 While reset_i=1, req_yumi_o SHALL be 0.
REQ-021 Reset during LOCKED SHALL abort the burst; any write registered in the reset cycle SHALL be dropped (w_v_o=0 the cycle after).

Verification
REQ-022 Reset, then all three valid, burst=0, continuously:
- grants 0,1,2,0,... one per cycle
- w_v_o follows one cycle after each yumi.
REQ-023 Requester 1 only, addr=30, mask=4'b0010, data={7,7,7,4}:
- next cycle w_v_o=4'b0010, w_addr_o=30, w_data_o[1]=7.
REQ-024 Requester 2 burst=1, valid for 6 cycles, requester 0 also valid:
- beats 2,2,2,2 with lock_o=1, then grant 0.
REQ-025 Requester 1 locked with burst=1, drops valid after 2 beats:
- one idle cycle with w_v_o=0, then ARB resumes at requester 2.
REQ-026 Stall for 3 cycles mid-burst:
- no yumi, beat_cnt_r frozen
- burst resumes after stall and ends at 4 total beats.
REQ-027 reset_i pulsed one cycle during a LOCKED beat:
- lock_o=0 next cycle, w_v_o=0
- the following arbitration grants requester 0 first.

Source files
------------

// File: rtl/simd_rf_wb_arbiter.sv
// Round-robin writeback arbiter feeding a SIMD register file write port.
// A requester asking for a burst locks the port for up to max_burst_p beats.
module simd_rf_wb_arbiter #(
    parameter int width_p       = 33,
    parameter int els_p         = 32,
    parameter int lanes_p       = 4,
    parameter int num_req_p     = 3,
    parameter int max_burst_p   = 4,
    parameter int addr_width_lp = $clog2(els_p)
) (
    input  logic                                           clk_i,
    input  logic                                           reset_i,
    input  logic                                           stall_i,
    input  logic [num_req_p-1:0]                           req_v_i,
    input  logic [num_req_p-1:0]                           req_burst_i,
    input  logic [num_req_p-1:0][addr_width_lp-1:0]        req_addr_i,
    input  logic [num_req_p-1:0][lanes_p-1:0]              req_mask_i,
    input  logic [num_req_p-1:0][lanes_p-1:0][width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]                           req_yumi_o,
    output logic [lanes_p-1:0]                             w_v_o,
    output logic [addr_width_lp-1:0]                       w_addr_o,
    output logic [lanes_p-1:0][width_p-1:0]                w_data_o,
    output logic                                           lock_o
);

    localparam int idx_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_width_lp = $clog2(max_burst_p + 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_e;

    state_e                            state_q, state_d;
    logic [idx_width_lp-1:0]           last_q, last_d;
    logic [idx_width_lp-1:0]           owner_q, owner_d;
    logic [cnt_width_lp-1:0]           beat_cnt_q, beat_cnt_d;
    logic [lanes_p-1:0]                w_v_q, w_v_d;
    logic [addr_width_lp-1:0]          w_addr_q, w_addr_d;
    logic [lanes_p-1:0][width_p-1:0]   w_data_q, w_data_d;

    logic                              arb_v;
    logic [idx_width_lp-1:0]           arb_idx;
    logic [idx_width_lp-1:0]           cand;
    logic                              gnt_v;
    logic [idx_width_lp-1:0]           gnt_idx;
    logic                              last_beat;

    // Scan starts just past the previous winner so every requester gets a turn.
    always_comb begin
        arb_v   = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = idx_width_lp'((int'(last_q) + i) % num_req_p);
            if (!arb_v && req_v_i[cand]) begin
                arb_v   = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        w_v_d      = '0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        gnt_v      = 1'b0;
        gnt_idx    = '0;
        last_beat  = 1'b0;

        if (!reset_i && !stall_i) begin
            case (state_q)
                ARB: begin
                    if (arb_v) begin
                        gnt_v   = 1'b1;
                        gnt_idx = arb_idx;
                        last_d  = arb_idx;
                        if (req_burst_i[arb_idx] && (max_burst_p > 1)) begin
                            state_d    = LOCKED;
                            owner_d    = arb_idx;
                            beat_cnt_d = cnt_width_lp'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Owner dropping valid ends the burst without a grant.
                    if (req_v_i[owner_q]) begin
                        gnt_v      = 1'b1;
                        gnt_idx    = owner_q;
                        last_d     = owner_q;
                        beat_cnt_d = beat_cnt_q + cnt_width_lp'(1);
                        last_beat  = !req_burst_i[owner_q] ||
                                     ((beat_cnt_q + cnt_width_lp'(1)) == cnt_width_lp'(max_burst_p));
                        if (last_beat) begin
                            state_d    = ARB;
                            beat_cnt_d = '0;
                        end
                    end else begin
                        state_d    = ARB;
                        beat_cnt_d = '0;
                    end
                end
                default: state_d = ARB;
            endcase
        end

        if (gnt_v) begin
            w_v_d    = req_mask_i[gnt_idx];
            w_addr_d = req_addr_i[gnt_idx];
            w_data_d = req_data_i[gnt_idx];
        end
    end

    always_comb begin
        req_yumi_o = '0;
        if (gnt_v) begin
            req_yumi_o[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ARB;
            last_q     <= idx_width_lp'(num_req_p - 1);
            owner_q    <= '0;
            beat_cnt_q <= '0;
            w_v_q      <= '0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            w_v_q      <= w_v_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign w_v_o    = w_v_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
    assign lock_o   = (state_q == LOCKED);

endmodule

// File: tb/tb_simd_rf_wb_arbiter.sv
// Directed self-checking bench for simd_rf_wb_arbiter with hand-computed
// grant sequences covering round-robin, bursts, stalls and reset.
module tb_simd_rf_wb_arbiter;

    localparam int width_p   = 33;
    localparam int lanes_p   = 4;
    localparam int num_req_p = 3;
    localparam int addr_w    = 5;

    logic                                           clk;
    logic                                           reset;
    logic                                           stall;
    logic [num_req_p-1:0]                           reqV;
    logic [num_req_p-1:0]                           reqBurst;
    logic [num_req_p-1:0][addr_w-1:0]               reqAddr;
    logic [num_req_p-1:0][lanes_p-1:0]              reqMask;
    logic [num_req_p-1:0][lanes_p-1:0][width_p-1:0] reqData;
    logic [num_req_p-1:0]                           reqYumi;
    logic [lanes_p-1:0]                             wV;
    logic [addr_w-1:0]                              wAddr;
    logic [lanes_p-1:0][width_p-1:0]                wData;
    logic                                           lock;

    int vectors;
    int miscompares;

    simd_rf_wb_arbiter dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .stall_i     (stall),
        .req_v_i     (reqV),
        .req_burst_i (reqBurst),
        .req_addr_i  (reqAddr),
        .req_mask_i  (reqMask),
        .req_data_i  (reqData),
        .req_yumi_o  (reqYumi),
        .w_v_o       (wV),
        .w_addr_o    (wAddr),
        .w_data_o    (wData),
        .lock_o      (lock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setReq(input int i, input logic v, input logic b, input logic [addr_w-1:0] a,
                          input logic [lanes_p-1:0] m, input logic [width_p-1:0] base);
        reqV[i]     = v;
        reqBurst[i] = b;
        reqAddr[i]  = a;
        reqMask[i]  = m;
        for (int l = 0; l < lanes_p; l++) begin
            reqData[i][l] = base + width_p'(l);
        end
    endtask

    // Inputs are already applied (just after a negedge): check the grant,
    // clock once, then check the registered write and lock state.
    task automatic applyStimulus(input string tag, input logic [2:0] expYumi,
                                 input logic [3:0] expWv, input logic expLock);
        #1;
        checkOutput({tag, "/yumi"}, 64'(reqYumi), 64'(expYumi));
        @(posedge clk);
        #1;
        checkOutput({tag, "/w_v"}, 64'(wV), 64'(expWv));
        checkOutput({tag, "/lock"}, 64'(lock), 64'(expLock));
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        reqV        = '0;
        reqBurst    = '0;
        reqAddr     = '0;
        reqMask     = '0;
        reqData     = '0;

        // Reset with every requester valid: nothing may be granted.
        setReq(0, 1'b1, 1'b0, 5'd10, 4'b0001, 33'h100);
        setReq(1, 1'b1, 1'b0, 5'd11, 4'b0010, 33'h200);
        setReq(2, 1'b1, 1'b0, 5'd12, 4'b0100, 33'h300);
        applyStimulus("rst0", 3'b000, 4'b0000, 1'b0);
        applyStimulus("rst1", 3'b000, 4'b0000, 1'b0);

        // Round robin 0,1,2,0 with write following one cycle later.
        reset = 1'b0;
        applyStimulus("rr0", 3'b001, 4'b0001, 1'b0);
        checkOutput("rr0/addr", 64'(wAddr), 64'd10);
        checkOutput("rr0/data0", 64'(wData[0]), 64'h100);
        applyStimulus("rr1", 3'b010, 4'b0010, 1'b0);
        checkOutput("rr1/addr", 64'(wAddr), 64'd11);
        applyStimulus("rr2", 3'b100, 4'b0100, 1'b0);
        checkOutput("rr2/addr", 64'(wAddr), 64'd12);
        checkOutput("rr2/data3", 64'(wData[3]), 64'h303);
        applyStimulus("rr3", 3'b001, 4'b0001, 1'b0);
        checkOutput("rr3/addr", 64'(wAddr), 64'd10);
        reqV = '0;
        applyStimulus("idle0", 3'b000, 4'b0000, 1'b0);

        // Single requester 1 with a sparse mask and mixed lane data.
        setReq(1, 1'b1, 1'b0, 5'd30, 4'b0010, 33'h0);
        reqData[1][3] = 33'd7;
        reqData[1][2] = 33'd7;
        reqData[1][1] = 33'd7;
        reqData[1][0] = 33'd4;
        applyStimulus("single1", 3'b010, 4'b0010, 1'b0);
        checkOutput("single1/addr", 64'(wAddr), 64'd30);
        checkOutput("single1/data1", 64'(wData[1]), 64'd7);
        checkOutput("single1/data0", 64'(wData[0]), 64'd4);
        reqV = '0;

        // Empty mask is still consumed but writes nothing (last=1 -> 0 wins).
        setReq(0, 1'b1, 1'b0, 5'd3, 4'b0000, 33'h50);
        applyStimulus("zmask", 3'b001, 4'b0000, 1'b0);
        reqV = '0;

        // Requester 2 bursts four beats while requester 0 waits (last=0).
        setReq(0, 1'b1, 1'b0, 5'd1, 4'b0001, 33'h10);
        setReq(2, 1'b1, 1'b1, 5'd2, 4'b1111, 33'h20);
        applyStimulus("burst2_b1", 3'b100, 4'b1111, 1'b1);
        applyStimulus("burst2_b2", 3'b100, 4'b1111, 1'b1);
        applyStimulus("burst2_b3", 3'b100, 4'b1111, 1'b1);
        applyStimulus("burst2_b4", 3'b100, 4'b1111, 1'b0);
        applyStimulus("burst2_then0", 3'b001, 4'b0001, 1'b0);
        checkOutput("burst2_then0/addr", 64'(wAddr), 64'd1);
        reqV = '0;
        applyStimulus("idle1", 3'b000, 4'b0000, 1'b0);

        // Requester 1 locks, drops valid after two beats (last=0).
        setReq(1, 1'b1, 1'b1, 5'd5, 4'b0011, 33'h40);
        applyStimulus("drop_b1", 3'b010, 4'b0011, 1'b1);
        applyStimulus("drop_b2", 3'b010, 4'b0011, 1'b1);
        reqV[1] = 1'b0;
        setReq(0, 1'b1, 1'b0, 5'd6, 4'b0001, 33'h60);
        setReq(2, 1'b1, 1'b0, 5'd7, 4'b0100, 33'h70);
        applyStimulus("drop_idle", 3'b000, 4'b0000, 1'b0);
        applyStimulus("drop_arb2", 3'b100, 4'b0100, 1'b0);
        checkOutput("drop_arb2/addr", 64'(wAddr), 64'd7);
        reqV = '0;

        // Requester 0 bursts with a 3-cycle stall mid-burst; requester 1 must wait.
        setReq(0, 1'b1, 1'b1, 5'd8, 4'b1000, 33'h80);
        setReq(1, 1'b1, 1'b0, 5'd9, 4'b0010, 33'h90);
        applyStimulus("stall_b1", 3'b001, 4'b1000, 1'b1);
        applyStimulus("stall_b2", 3'b001, 4'b1000, 1'b1);
        stall = 1'b1;
        applyStimulus("stall_s1", 3'b000, 4'b0000, 1'b1);
        applyStimulus("stall_s2", 3'b000, 4'b0000, 1'b1);
        applyStimulus("stall_s3", 3'b000, 4'b0000, 1'b1);
        stall = 1'b0;
        applyStimulus("stall_b3", 3'b001, 4'b1000, 1'b1);
        applyStimulus("stall_b4", 3'b001, 4'b1000, 1'b0);
        applyStimulus("stall_then1", 3'b010, 4'b0010, 1'b0);
        reqV = '0;

        // Reset pulse during a locked beat aborts it; requester 0 wins afterwards.
        setReq(2, 1'b1, 1'b1, 5'd15, 4'b0110, 33'hA0);
        applyStimulus("rlock_b1", 3'b100, 4'b0110, 1'b1);
        applyStimulus("rlock_b2", 3'b100, 4'b0110, 1'b1);
        reset = 1'b1;
        applyStimulus("rlock_rst", 3'b000, 4'b0000, 1'b0);
        reset = 1'b0;
        setReq(0, 1'b1, 1'b0, 5'd16, 4'b0101, 33'hB0);
        applyStimulus("rlock_after", 3'b001, 4'b0101, 1'b0);
        checkOutput("rlock_after/addr", 64'(wAddr), 64'd16);
        reqV = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
